stage4_decode_queue: RTL and testbench

Instruction buffer between the decode and execute stages of the four-stage pipeline. Decode pushes decoded instruction bundles, and execute consumes the head entry. The block obeys the hazard unit's `stall_queue` and `flush_queue` controls and reports `is_queue_full` back to the hazard unit, which uses it to stall decode.

---
 rtl/stage4_decode_queue_pkg.sv | 36 +++
 rtl/stage4_decode_queue.sv | 85 ++++++++
 tb/tb_stage4_decode_queue.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/stage4_decode_queue_pkg.sv
// Stage-4 pipeline shared types: decode-to-execute bundle and default queue depth.
package stage4_decode_queue_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned QUEUE_DEPTH = 4;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SLL  = 3'd5,
    ALU_SRL  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       reg_wen;
    logic       mem_ren;
    logic       mem_wen;
    logic       branch;
  } decode_ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    decode_ctrl_t    ctrl;
    logic            vsetvl;
  } decode_ex_t;

endpackage

// File: rtl/stage4_decode_queue.sv
// Circular instruction buffer between decode and execute with stall/flush control.
module stage4_decode_queue
  import stage4_decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = QUEUE_DEPTH,
  parameter int unsigned ENTRY_W = $bits(decode_ex_t)
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       queue_wen,
  input  logic [ENTRY_W-1:0]         wdata,
  input  logic                       stall_queue,
  input  logic                       flush_queue,
  output logic [ENTRY_W-1:0]         rdata,
  output logic                       rvalid,
  output logic                       is_queue_full,
  output logic                       is_queue_empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rptr;
  logic [PTR_W-1:0]   wptr;
  logic               push;
  logic               pop;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Status and head outputs derive from registers only.
  assign rvalid         = (count != '0);
  assign is_queue_empty = (count == '0);
  assign is_queue_full  = (count == CNT_W'(DEPTH));
  assign rdata          = mem[rptr];

  // Flush overrides everything; a push while full only succeeds alongside a pop.
  always_comb begin
    pop  = 1'b0;
    push = 1'b0;
    pop  = rvalid && !stall_queue && !flush_queue;
    push = queue_wen && !flush_queue && (!is_queue_full || pop);
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush_queue) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        rptr <= ptr_inc(rptr);
      end
      if (push) begin
        wptr <= ptr_inc(wptr);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Entry storage; cleared on reset but left intact by flush.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wptr] <= wdata;
    end
  end

endmodule

// File: tb/tb_stage4_decode_queue.sv
// Directed bench for stage4_decode_queue at DEPTH=4, ENTRY_W=32.
module tb_stage4_decode_queue;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned ENTRY_W = 32;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  logic               clk;
  logic               rst_n;
  logic               queue_wen;
  logic [ENTRY_W-1:0] wdata;
  logic               stall_queue;
  logic               flush_queue;
  logic [ENTRY_W-1:0] rdata;
  logic               rvalid;
  logic               is_queue_full;
  logic               is_queue_empty;
  logic [CNT_W-1:0]   count;

  int n_assert;
  int n_fail;
  int drop_cnt;

  stage4_decode_queue #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) dut (
    .CLK            (clk),
    .nRST           (rst_n),
    .queue_wen      (queue_wen),
    .wdata          (wdata),
    .stall_queue    (stall_queue),
    .flush_queue    (flush_queue),
    .rdata          (rdata),
    .rvalid         (rvalid),
    .is_queue_full  (is_queue_full),
    .is_queue_empty (is_queue_empty),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol monitor: a push request while full with no pop is a dropped bundle.
  always @(posedge clk) begin
    if (rst_n && queue_wen && !flush_queue && is_queue_full
        && !(rvalid && !stall_queue)) begin
      drop_cnt++;
      $display("protocol violation: push of %h dropped while queue full", wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic v, input logic [31:0] d,
                             input logic [CNT_W-1:0] c, input logic f, input logic e);
    check({tag, ".rvalid"}, 32'(rvalid), 32'(v));
    if (v) check({tag, ".rdata"}, rdata, d);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".full"}, 32'(is_queue_full), 32'(f));
    check({tag, ".empty"}, 32'(is_queue_empty), 32'(e));
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    drop_cnt    = 0;
    rst_n       = 1'b0;
    queue_wen   = 1'b0;
    wdata       = '0;
    stall_queue = 1'b0;
    flush_queue = 1'b0;

    // Reset state
    step();
    step();
    check("reset.rdata", rdata, 32'h0);
    check_state("reset", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
    rst_n = 1'b1;
    step();

    // Fill with stall held, head stays on the oldest entry
    stall_queue = 1'b1;
    queue_wen   = 1'b1;
    wdata = 32'hA0; step();
    check_state("fill1", 1'b1, 32'hA0, 3'd1, 1'b0, 1'b0);
    wdata = 32'hA1; step();
    wdata = 32'hA2; step();
    check_state("fill3", 1'b1, 32'hA0, 3'd3, 1'b0, 1'b0);
    wdata = 32'hA3; step();
    check_state("fill4", 1'b1, 32'hA0, 3'd4, 1'b1, 1'b0);

    // Overflow: push while full and stalled is dropped
    wdata = 32'hBB; step();
    check_state("ovf", 1'b1, 32'hA0, 3'd4, 1'b1, 1'b0);
    check("ovf.drop_seen", 32'(drop_cnt), 32'd1);

    // Drain in order, BB must never surface
    queue_wen   = 1'b0;
    stall_queue = 1'b0;
    step(); check_state("drain1", 1'b1, 32'hA1, 3'd3, 1'b0, 1'b0);
    step(); check_state("drain2", 1'b1, 32'hA2, 3'd2, 1'b0, 1'b0);
    step(); check_state("drain3", 1'b1, 32'hA3, 3'd1, 1'b0, 1'b0);
    step(); check_state("drain4", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);

    // Offset pointers by one so the full push+pop run crosses the wrap
    queue_wen = 1'b1; wdata = 32'h11; step();
    queue_wen = 1'b0; step();
    check_state("offset", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);

    // Fill with stall, then sustained push+pop while full
    stall_queue = 1'b1;
    queue_wen   = 1'b1;
    wdata = 32'hC0; step();
    wdata = 32'hC1; step();
    wdata = 32'hC2; step();
    wdata = 32'hC3; step();
    check_state("wfull", 1'b1, 32'hC0, 3'd4, 1'b1, 1'b0);
    stall_queue = 1'b0;
    wdata = 32'hC4; step();
    check_state("wrap1", 1'b1, 32'hC1, 3'd4, 1'b1, 1'b0);
    wdata = 32'hC5; step();
    check_state("wrap2", 1'b1, 32'hC2, 3'd4, 1'b1, 1'b0);
    queue_wen = 1'b0;
    step(); check_state("wdrain1", 1'b1, 32'hC3, 3'd3, 1'b0, 1'b0);
    step(); check_state("wdrain2", 1'b1, 32'hC4, 3'd2, 1'b0, 1'b0);
    step(); check_state("wdrain3", 1'b1, 32'hC5, 3'd1, 1'b0, 1'b0);
    step(); check_state("wdrain4", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);

    // Flush priority over a same-cycle push
    stall_queue = 1'b1;
    queue_wen   = 1'b1;
    wdata = 32'h21; step();
    wdata = 32'h22; step();
    check_state("preflush", 1'b1, 32'h21, 3'd2, 1'b0, 1'b0);
    flush_queue = 1'b1;
    wdata = 32'hD0; step();
    check_state("flush", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
    flush_queue = 1'b0;
    wdata = 32'hD1; step();
    check_state("postflush", 1'b1, 32'hD1, 3'd1, 1'b0, 1'b0);
    queue_wen   = 1'b0;
    stall_queue = 1'b0;
    step();
    check_state("postflush_drain", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);

    // Empty-queue latency: no same-cycle bypass, head valid one edge later
    queue_wen = 1'b1;
    wdata     = 32'hE0;
    #1;
    check("lat.no_bypass", 32'(rvalid), 32'd0);
    step();
    queue_wen = 1'b0;
    stall_queue = 1'b1;
    check_state("lat", 1'b1, 32'hE0, 3'd1, 1'b0, 1'b0);

    // Mid-stream async reset with three entries
    queue_wen = 1'b1;
    wdata = 32'h31; step();
    wdata = 32'h32; step();
    check_state("prerst", 1'b1, 32'hE0, 3'd3, 1'b0, 1'b0);
    queue_wen = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.rdata", rdata, 32'h0);
    check_state("rst_mid", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
    step();
    rst_n = 1'b1;
    stall_queue = 1'b0;
    step();
    check_state("rst_after", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
    check("drop_total", 32'(drop_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
